// File: rtl/cin_code_tx.sv
// Serial entry-code transmitter: shifts a CODE_W-bit code out on cin MSB-first, BIT_CYC clocks per bit,
// then holds cin low for GAP_CYC clocks and pulses done on return to IDLE.
module cin_code_tx #(
  parameter int                 CODE_W   = 3,
  parameter logic [CODE_W-1:0]  CODE_DEF = 3'b101,
  parameter int                 BIT_CYC  = 1,
  parameter int                 GAP_CYC  = 2
) (
  input  logic              clk,
  input  logic              enter_n,
  input  logic              start,
  input  logic              use_def,
  input  logic [CODE_W-1:0] code_in,
  output logic              cin,
  output logic              bit_strobe,
  output logic              busy,
  output logic              done
);

  localparam int CYC_W = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam int IDX_W = (CODE_W  > 1) ? $clog2(CODE_W)  : 1;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t            state;
  logic [CODE_W-1:0] shreg;
  logic [CODE_W-1:0] sh_next;
  logic [CODE_W-1:0] load_code;
  logic [CYC_W-1:0]  cyc_cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic [GAP_W-1:0]  gap_cnt;

  assign sh_next   = shreg << 1;
  assign load_code = use_def ? CODE_DEF : code_in;

  always_ff @(posedge clk) begin
    if (!enter_n) begin
      state      <= IDLE;
      shreg      <= '0;
      cyc_cnt    <= '0;
      bit_idx    <= '0;
      gap_cnt    <= '0;
      cin        <= 1'b0;
      bit_strobe <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done       <= 1'b0;
      bit_strobe <= 1'b0;
      case (state)
        IDLE: begin
          cin  <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            shreg      <= load_code;
            bit_idx    <= IDX_W'(CODE_W - 1);
            cyc_cnt    <= '0;
            state      <= SEND;
            cin        <= load_code[CODE_W-1];
            busy       <= 1'b1;
            bit_strobe <= 1'b1;
          end
        end
        SEND: begin
          if (cyc_cnt == CYC_W'(BIT_CYC - 1)) begin
            cyc_cnt <= '0;
            if (bit_idx == '0) begin
              cin <= 1'b0;
              // With no gap configured the frame completes straight from the last bit.
              if (GAP_CYC == 0) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state   <= GAP;
                gap_cnt <= '0;
              end
            end else begin
              shreg      <= sh_next;
              bit_idx    <= bit_idx - IDX_W'(1);
              cin        <= sh_next[CODE_W-1];
              bit_strobe <= 1'b1;
            end
          end else begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
          end
        end
        GAP: begin
          cin <= 1'b0;
          if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
            gap_cnt <= '0;
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cin   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cin_code_tx.sv
// Bench for cin_code_tx: per-cycle expected {cin,bit_strobe,busy,done} queued at stimulus time, popped on each falling edge.
module tb_cin_code_tx;

  logic       clk;
  logic       enter_n;
  logic       start, use_def;
  logic [2:0] code_in;
  logic       cin, bit_strobe, busy, done;
  logic       start5, use_def5;
  logic [2:0] code_in5;
  logic       cin5, bit_strobe5, busy5, done5;

  int    checks = 0;
  int    errors = 0;
  int    cyc_no = 0;
  string cur_test = "none";
  logic [3:0] exp_q[$];

  cin_code_tx dut (
    .clk(clk), .enter_n(enter_n), .start(start), .use_def(use_def), .code_in(code_in),
    .cin(cin), .bit_strobe(bit_strobe), .busy(busy), .done(done)
  );

  cin_code_tx #(.CODE_W(3), .CODE_DEF(3'b101), .BIT_CYC(3), .GAP_CYC(0)) dut5 (
    .clk(clk), .enter_n(enter_n), .start(start5), .use_def(use_def5), .code_in(code_in5),
    .cin(cin5), .bit_strobe(bit_strobe5), .busy(busy5), .done(done5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs for one full frame, from the first cycle after the start edge through the done cycle.
  task automatic push_frame(input logic [2:0] code, input int bc, input int gc);
    for (int b = 2; b >= 0; b--)
      for (int c = 0; c < bc; c++)
        exp_q.push_back({code[b], (c == 0), 1'b1, 1'b0});
    for (int g = 0; g < gc; g++)
      exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0001);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(4'b0000);
  endtask

  task automatic tick(input bit sel);
    logic [3:0] act;
    logic [3:0] exp;
    @(posedge clk);
    @(negedge clk);
    cyc_no++;
    act = sel ? {cin5, bit_strobe5, busy5, done5} : {cin, bit_strobe, busy, done};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s cycle %0d: no expectation queued, got {cin,strobe,busy,done}=%b", cur_test, cyc_no, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        errors++;
        $display("FAIL %s cycle %0d: {cin,strobe,busy,done}=%b expected %b", cur_test, cyc_no, act, exp);
      end
    end
  endtask

  task automatic begin_test(input string name);
    cur_test = name;
    cyc_no = 0;
  endtask

  task automatic test_reset;
    begin_test("reset");
    enter_n = 1'b0; start = 1'b1; use_def = 1'b0; code_in = 3'b111;
    push_idle(3);
    repeat (3) tick(0);
    enter_n = 1'b1; start = 1'b0;
    push_idle(2);
    repeat (2) tick(0);
  endtask

  task automatic test_basic;
    begin_test("basic_101");
    start = 1'b1; use_def = 1'b0; code_in = 3'b101;
    push_frame(3'b101, 1, 2);
    tick(0);
    start = 1'b0;
    repeat (5) tick(0);
    push_idle(2);
    repeat (2) tick(0);
  endtask

  task automatic test_start_held;
    begin_test("start_held");
    start = 1'b1; use_def = 1'b0; code_in = 3'b101;
    push_frame(3'b101, 1, 2);
    push_frame(3'b011, 1, 2);
    tick(0);
    code_in = 3'b011;
    repeat (6) tick(0);
    start = 1'b0;
    repeat (5) tick(0);
    push_idle(1);
    tick(0);
  endtask

  task automatic test_mid_reset;
    begin_test("mid_reset");
    start = 1'b1; use_def = 1'b0; code_in = 3'b101;
    exp_q.push_back(4'b1110);
    exp_q.push_back(4'b0110);
    tick(0);
    start = 1'b0;
    tick(0);
    enter_n = 1'b0;
    push_idle(1);
    tick(0);
    enter_n = 1'b1;
    push_idle(5);
    repeat (5) tick(0);
    begin_test("after_reset");
    start = 1'b1; code_in = 3'b110;
    push_frame(3'b110, 1, 2);
    tick(0);
    start = 1'b0;
    repeat (5) tick(0);
  endtask

  task automatic test_slow_nogap;
    begin_test("bitcyc3_gap0");
    start5 = 1'b1; use_def5 = 1'b0; code_in5 = 3'b110;
    push_frame(3'b110, 3, 0);
    tick(1);
    start5 = 1'b0; code_in5 = 3'b001;
    repeat (9) tick(1);
    push_idle(2);
    repeat (2) tick(1);
  endtask

  task automatic test_use_def;
    begin_test("use_def");
    start = 1'b1; use_def = 1'b1; code_in = 3'b000;
    push_frame(3'b101, 1, 2);
    tick(0);
    start = 1'b0; use_def = 1'b0;
    repeat (5) tick(0);
    push_idle(1);
    tick(0);
  endtask

  task automatic test_back_to_back;
    logic [2:0] codes[4];
    begin_test("back_to_back");
    for (int i = 0; i < 4; i++) codes[i] = 3'($urandom_range(0, 7));
    use_def = 1'b0;
    start = 1'b1;
    for (int f = 0; f < 4; f++) begin
      code_in = codes[f];
      push_frame(codes[f], 1, 2);
      tick(0);
      code_in = ~codes[f];
      if (f == 3) start = 1'b0;
      repeat (5) tick(0);
    end
    push_idle(2);
    repeat (2) tick(0);
  endtask

  initial begin
    start5 = 1'b0; use_def5 = 1'b0; code_in5 = 3'b000;
    test_reset;
    test_basic;
    test_start_held;
    test_mid_reset;
    test_slow_nogap;
    test_use_def;
    test_back_to_back;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations: %0d left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
